// File: rtl/masked_inv_prng.sv
// Seeded xorshift32 randomness source for a masked GF(2^8) inverter.
// Optional reseed-interval counter enabled by defining MASKED_INV_PRNG_RESEED_EN.
package masked_inv_prng_pkg;
  localparam int HPC1 = 0;
  localparam int HPC3 = 1;
  localparam int DEFAULT_STAGE_TYPE = HPC1;

  // Fresh random bits consumed per inverter evaluation, by share count and gadget type.
  function automatic int num_inv_random(input int num_shares, input int stage_type);
    int pairs;
    pairs = num_shares * (num_shares - 1) / 2;
    if (stage_type == HPC3) return 36 * pairs;
    return 18 * pairs + 16 * (num_shares - 1);
  endfunction
endpackage

module masked_inv_prng
  import masked_inv_prng_pkg::*;
#(
  parameter int NUM_SHARES      = 2,
  parameter int STAGE_TYPE      = DEFAULT_STAGE_TYPE,
  parameter int RESEED_INTERVAL = 1024,
  localparam int NUM_RANDOM     = num_inv_random(NUM_SHARES, STAGE_TYPE),
  localparam int NUM_LANES      = (NUM_RANDOM + 31) / 32
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic [31:0]           in_seed,
  input  logic                  in_seed_valid,
  output logic                  out_seed_ready,
  input  logic                  in_reseed,
  input  logic                  in_enable,
  output logic [NUM_RANDOM-1:0] out_random,
  output logic                  out_valid,
  output logic                  out_reseed_req
);

  localparam int          LCW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [31:0] ZERO_SUBST = 32'h6D2B_79F5;

  if (NUM_SHARES < 2 || (STAGE_TYPE != HPC1 && STAGE_TYPE != HPC3) ||
      RESEED_INTERVAL < 1 || RESEED_INTERVAL > (1 << 20)) begin : g_bad_param
    $error("masked_inv_prng: parameter out of range");
  end

  typedef enum logic [1:0] {UNSEEDED, SEEDING, RUN} state_t;

  state_t                 r_state;
  logic [LCW-1:0]         r_lane_cnt;
  logic [31:0]            r_lanes [NUM_LANES];
  logic                   r_valid;
  logic                   r_seed_ready;
  logic [31:0]            w_step  [NUM_LANES];
  logic [32*NUM_LANES-1:0] w_flat;
  logic [31:0]            w_seed_word;
  logic                   w_step_en;
  logic                   w_enter_seeding;

  genvar gi;
  for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [31:0] w_a;
    logic [31:0] w_b;
    assign w_a        = r_lanes[gi] ^ (r_lanes[gi] << 13);
    assign w_b        = w_a ^ (w_a >> 17);
    assign w_step[gi] = w_b ^ (w_b << 5);
    assign w_flat[32*gi +: 32] = r_lanes[gi];
  end

  // An all-zero xorshift state would lock up, so zero seeds are substituted.
  assign w_seed_word     = (in_seed == 32'd0) ? ZERO_SUBST : in_seed;
  assign w_step_en       = (r_state == RUN) && in_enable && !in_reseed;
  assign w_enter_seeding = (r_state == UNSEEDED) || ((r_state == RUN) && in_reseed);

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_state      <= UNSEEDED;
      r_lane_cnt   <= '0;
      r_valid      <= 1'b0;
      r_seed_ready <= 1'b0;
      for (int j = 0; j < NUM_LANES; j++) r_lanes[j] <= '0;
    end else begin
      case (r_state)
        UNSEEDED: begin
          r_state      <= SEEDING;
          r_seed_ready <= 1'b1;
        end
        SEEDING: begin
          if (in_seed_valid) begin
            for (int j = 0; j < NUM_LANES; j++)
              if (r_lane_cnt == LCW'(j)) r_lanes[j] <= w_seed_word;
            if (r_lane_cnt == LCW'(NUM_LANES - 1)) begin
              r_state      <= RUN;
              r_seed_ready <= 1'b0;
              r_valid      <= 1'b1;
            end else begin
              r_lane_cnt <= r_lane_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (in_reseed) begin
            r_state      <= SEEDING;
            r_lane_cnt   <= '0;
            r_valid      <= 1'b0;
            r_seed_ready <= 1'b1;
          end else if (in_enable) begin
            for (int j = 0; j < NUM_LANES; j++) r_lanes[j] <= w_step[j];
          end
        end
        default: begin
          r_state      <= UNSEEDED;
          r_valid      <= 1'b0;
          r_seed_ready <= 1'b0;
        end
      endcase
    end
  end

  assign out_random     = r_valid ? NUM_RANDOM'(w_flat) : '0;
  assign out_valid      = r_valid;
  assign out_seed_ready = r_seed_ready;

`ifdef MASKED_INV_PRNG_RESEED_EN
  localparam logic [20:0] INTERVAL = 21'(RESEED_INTERVAL);

  logic [20:0] r_reseed_cnt;
  logic        r_reseed_req;

  // Counter saturates at the interval; the request stays up until seeding restarts.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_reseed_cnt <= '0;
      r_reseed_req <= 1'b0;
    end else if (w_enter_seeding) begin
      r_reseed_cnt <= '0;
      r_reseed_req <= 1'b0;
    end else if (w_step_en) begin
      if (r_reseed_cnt != INTERVAL) r_reseed_cnt <= r_reseed_cnt + 21'd1;
      if (r_reseed_cnt >= INTERVAL - 21'd1) r_reseed_req <= 1'b1;
    end
  end

  assign out_reseed_req = r_reseed_req;
`else
  assign out_reseed_req = 1'b0;
`endif

endmodule

// File: doc/masked_inv_prng.md
MASKED_INV_PRNG -- requirements
Module: masked_inv_prng

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 2, share count of the attached masked GF(2^8) inverter.
REQ-002 SHALL have parameter STAGE_TYPE, default DEFAULT_STAGE_TYPE, inverter stage-2 gadget type (HPC1/HPC3).
REQ-003 SHALL have parameter RESEED_INTERVAL, default 1024, RUN cycles between reseed requests (1..2^20).
REQ-004 SHALL derive localparam NUM_RANDOM = num_inv_random(NUM_SHARES, STAGE_TYPE) and NUM_LANES = (NUM_RANDOM+31)/32.
REQ-005 in_clock  input  1  sole clock, rising edge.
REQ-006 in_reset  input  1  asynchronous reset, active-low (asserted at 0).
REQ-007 in_seed  input  32  seed word.
REQ-008 in_seed_valid  input  1  seed word offered.
REQ-009 out_seed_ready  output  1  seed word accepted when high with in_seed_valid.
REQ-010 in_reseed  input  1  single-cycle request to re-enter seeding.
REQ-011 in_enable  input  1  advance generator this cycle.
REQ-012 out_random  output  NUM_RANDOM  fresh randomness for the inverter's in_random port.
REQ-013 out_valid  output  1  out_random is usable this cycle.
REQ-014 out_reseed_req  output  1  reseed recommended (sticky until seeding starts).

Function
REQ-015 Generator SHALL hold NUM_LANES 32-bit xorshift32 lanes; step: x^=x<<13; x^=x>>17; x^=x<<5.
REQ-016 out_random SHALL equal the registered lane states, lane j at bits [32j +: 32], truncated to NUM_RANDOM bits (no combinational path from inputs).
REQ-017 FSM states: UNSEEDED, SEEDING, RUN.
REQ-018 UNSEEDED -> SEEDING on first cycle after reset release; out_seed_ready=1 in SEEDING only.
REQ-019 SEEDING: each accepted word loads lane k (k counts 0..NUM_LANES-1); zero word SHALL be replaced by 0x6D2B79F5; after lane NUM_LANES-1 loaded -> RUN next cycle.
REQ-020 RUN: out_valid=1; lanes step on cycles with in_enable=1, hold otherwise; new value visible one cycle after enabled edge.
REQ-021 Outside RUN: out_valid=0, out_random=0, lanes do not step.
REQ-022 in_reseed in RUN -> SEEDING next cycle, lane counter cleared, out_valid drops same edge; in_reseed outside RUN ignored.
REQ-023 in_reseed and in_enable in same RUN cycle: reseed wins, no step.
REQ-024 in_seed_valid outside SEEDING SHALL be ignored (no lane change).

Reset
REQ-025 While in_reset=0: state UNSEEDED, lanes 0, lane counter 0, reseed counter 0, out_valid=0, out_seed_ready=0, out_reseed_req=0, out_random=0.
REQ-026 Reset asserted mid-SEEDING or mid-RUN SHALL discard all seed material; full reseed required afterwards.

Configuration
REQ-027 Macro MASKED_INV_PRNG_RESEED_EN defined: counter increments on each enabled RUN step, sets out_reseed_req at RESEED_INTERVAL (saturating), clears on entry to SEEDING.
REQ-028 Macro undefined: no counter logic; out_reseed_req tied 0; RESEED_INTERVAL unused.

Verification
REQ-029 NUM_SHARES=2, seed all lanes 0x00000001, one enable -> each lane reads 0x00042021, out_valid=1.
REQ-030 Seed word 0 to lane 0 -> lane 0 reads 0x6D2B79F5 before first step.
REQ-031 in_enable=0 for 10 RUN cycles -> out_random unchanged; then enable -> single step.
REQ-032 in_reseed with in_enable=1 in RUN -> next cycle out_valid=0, out_seed_ready=1, lanes unchanged.
REQ-033 With MASKED_INV_PRNG_RESEED_EN, RESEED_INTERVAL=4, 4 enabled steps -> out_reseed_req=1 until reseed starts.
REQ-034 Reset pulse low during SEEDING after 1 word -> all outputs 0, then seeding restarts at lane 0.
